// File: rtl/butterfly_writeback.sv
// Serialises one butterfly result into four sample-RAM writes (A re, A im, B re, B im).
// Optional macro WB_OVERLAP_EN lets the next result be captured on the final write edge.
module butterfly_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_real,
  input  logic [DATA_W-1:0] a_imag,
  input  logic [DATA_W-1:0] b_real,
  input  logic [DATA_W-1:0] b_imag,
  input  logic [ADDR_W-1:0] a_real_addr,
  input  logic [ADDR_W-1:0] a_imag_addr,
  input  logic [ADDR_W-1:0] b_real_addr,
  input  logic [ADDR_W-1:0] b_imag_addr,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_slot,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StWrRa, StWrIa, StWrRb, StWrIb} state_e;

  state_e state_q, state_d;

  // Slot 0 goes straight into the write registers at capture; these hold slots 1..3.
  logic [2:0][DATA_W-1:0] hold_data_q, hold_data_d;
  logic [2:0][ADDR_W-1:0] hold_addr_q, hold_addr_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_slot_q, wr_slot_d;
  logic              done_q, done_d;

  logic fire;
  logic capture;

  assign fire = wr_en_q & mem_ready;

`ifdef WB_OVERLAP_EN
  assign in_ready = (state_q == StIdle) | ((state_q == StWrIb) & mem_ready);
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign capture = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_slot_d   = wr_slot_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StWrRa: begin
        if (fire) begin
          state_d   = StWrIa;
          wr_addr_d = hold_addr_q[0];
          wr_data_d = hold_data_q[0];
          wr_slot_d = 2'd1;
        end
      end
      StWrIa: begin
        if (fire) begin
          state_d   = StWrRb;
          wr_addr_d = hold_addr_q[1];
          wr_data_d = hold_data_q[1];
          wr_slot_d = 2'd2;
        end
      end
      StWrRb: begin
        if (fire) begin
          state_d   = StWrIb;
          wr_addr_d = hold_addr_q[2];
          wr_data_d = hold_data_q[2];
          wr_slot_d = 2'd3;
        end
      end
      StWrIb: begin
        if (fire) begin
          state_d = StIdle;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A capture overrides the idle/completion defaults; done above is left intact.
    if (capture) begin
      state_d     = StWrRa;
      hold_data_d = {b_imag, b_real, a_imag};
      hold_addr_d = {b_imag_addr, b_real_addr, a_imag_addr};
      wr_en_d     = 1'b1;
      wr_addr_d   = a_real_addr;
      wr_data_d   = a_real;
      wr_slot_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_slot_q   <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_slot_q   <= wr_slot_d;
      done_q      <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_slot = wr_slot_q;
  assign done    = done_q;

endmodule

// File: tb/tb_butterfly_writeback.sv
// Self-checking bench for butterfly_writeback: directed vector tables plus a queue-based
// transaction model driven with random traffic. Honours WB_OVERLAP_EN like the design.
module tb_butterfly_writeback;

  localparam int DW = 16;
  localparam int AW = 10;
`ifdef WB_OVERLAP_EN
  localparam bit Ovl = 1'b1;
`else
  localparam bit Ovl = 1'b0;
`endif

  logic          clk, rst, in_valid, in_ready, mem_ready, wr_en, done;
  logic [DW-1:0] a_real, a_imag, b_real, b_imag, wr_data;
  logic [AW-1:0] a_real_addr, a_imag_addr, b_real_addr, b_imag_addr, wr_addr;
  logic [1:0]    wr_slot;

  butterfly_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_real     (a_real),
    .a_imag     (a_imag),
    .b_real     (b_real),
    .b_imag     (b_imag),
    .a_real_addr(a_real_addr),
    .a_imag_addr(a_imag_addr),
    .b_real_addr(b_real_addr),
    .b_imag_addr(b_imag_addr),
    .mem_ready  (mem_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_slot    (wr_slot),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    slot;
  } wr_t;

  typedef struct {
    logic          iv;
    logic          mr;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    slot;
    logic          done;
    logic          rdy;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: writes still owed for the result in flight, oldest first.
  wr_t  pend[$];
  wr_t  last;
  logic m_done;
  int   m_caps;

  logic [DW-1:0] mem [1<<AW];
  int   n_wr_3ff;
  logic s_en, s_done;
  vec_t nov;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_rdy();
    return (pend.size() == 0) || (Ovl && pend.size() == 1 && mem_ready);
  endfunction

  task automatic model_reset();
    pend.delete();
    last   = '0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_inputs();
    a_real      = DW'($urandom);
    a_imag      = DW'($urandom);
    b_real      = DW'($urandom);
    b_imag      = DW'($urandom);
    a_real_addr = AW'($urandom);
    a_imag_addr = AW'($urandom);
    b_real_addr = AW'($urandom);
    b_imag_addr = AW'($urandom);
  endtask

  // One clock cycle: compare at the falling edge, then advance the model across the rising edge.
  task automatic tick(input bit use_vec, input vec_t v);
    wr_t head;
    bit  en_e, fire, cap;
    @(negedge clk);
    en_e = (pend.size() != 0);
    head = en_e ? pend[0] : last;
    chk("wr_en", 32'(wr_en), 32'(en_e));
    chk("wr_addr", 32'(wr_addr), 32'(head.addr));
    chk("wr_data", 32'(wr_data), 32'(head.data));
    chk("wr_slot", 32'(wr_slot), 32'(head.slot));
    chk("done", 32'(done), 32'(m_done));
    chk("in_ready", 32'(in_ready), 32'(m_rdy()));
    if (use_vec) begin
      chk("vec_wr_en", 32'(wr_en), 32'(v.en));
      chk("vec_wr_addr", 32'(wr_addr), 32'(v.addr));
      chk("vec_wr_data", 32'(wr_data), 32'(v.data));
      chk("vec_wr_slot", 32'(wr_slot), 32'(v.slot));
      chk("vec_done", 32'(done), 32'(v.done));
      chk("vec_in_ready", 32'(in_ready), 32'(v.rdy));
    end
    s_en   = wr_en;
    s_done = done;
    if (wr_en && mem_ready) begin
      mem[wr_addr] = wr_data;
      if (wr_addr == '1) n_wr_3ff++;
    end
    fire = en_e && mem_ready;
    cap  = in_valid && m_rdy();
    @(posedge clk);
    m_done = 1'b0;
    if (fire) begin
      last = pend.pop_front();
      if (pend.size() == 0) m_done = 1'b1;
    end
    if (cap) begin
      pend.push_back('{addr: a_real_addr, data: a_real, slot: 2'd0});
      pend.push_back('{addr: a_imag_addr, data: a_imag, slot: 2'd1});
      pend.push_back('{addr: b_real_addr, data: b_real, slot: 2'd2});
      pend.push_back('{addr: b_imag_addr, data: b_imag, slot: 2'd3});
      m_caps++;
    end
    cyc++;
    #1;
  endtask

  vec_t single_v[7];
  vec_t stall_v[8];
  int   done_at[3];

  initial begin
    int nd, en_cnt, run, maxrun;
    logic [DW-1:0] bim;

    nov = '{default: '0};
    single_v[0] = '{1'b1, 1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 1'b0, 1'b1};
    single_v[1] = '{1'b0, 1'b1, 1'b1, 10'h010, 16'h0011, 2'd0, 1'b0, 1'b0};
    single_v[2] = '{1'b0, 1'b1, 1'b1, 10'h011, 16'h0022, 2'd1, 1'b0, 1'b0};
    single_v[3] = '{1'b0, 1'b1, 1'b1, 10'h210, 16'h0033, 2'd2, 1'b0, 1'b0};
    single_v[4] = '{1'b0, 1'b1, 1'b1, 10'h211, 16'h0044, 2'd3, 1'b0, Ovl};
    single_v[5] = '{1'b0, 1'b1, 1'b0, 10'h211, 16'h0044, 2'd3, 1'b1, 1'b1};
    single_v[6] = '{1'b0, 1'b1, 1'b0, 10'h211, 16'h0044, 2'd3, 1'b0, 1'b1};
    stall_v[0]  = '{1'b1, 1'b1, 1'b0, 10'h211, 16'h0044, 2'd3, 1'b0, 1'b1};
    stall_v[1]  = '{1'b0, 1'b1, 1'b1, 10'h010, 16'h0011, 2'd0, 1'b0, 1'b0};
    stall_v[2]  = '{1'b0, 1'b0, 1'b1, 10'h011, 16'h0022, 2'd1, 1'b0, 1'b0};
    stall_v[3]  = '{1'b0, 1'b0, 1'b1, 10'h011, 16'h0022, 2'd1, 1'b0, 1'b0};
    stall_v[4]  = '{1'b0, 1'b1, 1'b1, 10'h011, 16'h0022, 2'd1, 1'b0, 1'b0};
    stall_v[5]  = '{1'b0, 1'b1, 1'b1, 10'h210, 16'h0033, 2'd2, 1'b0, 1'b0};
    stall_v[6]  = '{1'b0, 1'b1, 1'b1, 10'h211, 16'h0044, 2'd3, 1'b0, Ovl};
    stall_v[7]  = '{1'b0, 1'b1, 1'b0, 10'h211, 16'h0044, 2'd3, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b1; m_caps = 0; n_wr_3ff = 0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    a_real_addr = '0; a_imag_addr = '0; b_real_addr = '0; b_imag_addr = '0;
    do_reset();

    // Single result and stall, from the directed tables.
    a_real = 16'h0011; a_imag = 16'h0022; b_real = 16'h0033; b_imag = 16'h0044;
    a_real_addr = 10'h010; a_imag_addr = 10'h011; b_real_addr = 10'h210; b_imag_addr = 10'h211;
    for (int i = 0; i < 7; i++) begin
      in_valid = single_v[i].iv; mem_ready = single_v[i].mr;
      tick(1'b1, single_v[i]);
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = stall_v[i].iv; mem_ready = stall_v[i].mr;
      tick(1'b1, stall_v[i]);
    end

    // Asynchronous reset while the B-real write is presented.
    in_valid = 1'b1; tick(1'b0, nov);
    in_valid = 1'b0; tick(1'b0, nov); tick(1'b0, nov);
    chk("pre_rst_slot", 32'(wr_slot), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick(1'b0, nov);

    // Upstream keeps changing after capture; writes must reflect captured values.
    in_valid = 1'b1; tick(1'b0, nov);
    for (int i = 0; i < 5; i++) begin
      rand_inputs(); tick(1'b0, nov);
    end
    in_valid = 1'b0;
    repeat (10) tick(1'b0, nov);

    // All four destinations collide: last slot wins.
    rand_inputs();
    a_real_addr = '1; a_imag_addr = '1; b_real_addr = '1; b_imag_addr = '1;
    bim = b_imag; n_wr_3ff = 0;
    in_valid = 1'b1; tick(1'b0, nov);
    in_valid = 1'b0;
    repeat (6) tick(1'b0, nov);
    chk("collide_count", 32'(n_wr_3ff), 32'd4);
    chk("collide_mem", 32'(mem[10'h3ff]), 32'(bim));

    // Three results with in_valid held high.
    m_caps = 0; nd = 0; en_cnt = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = (m_caps < 3);
      rand_inputs();
      tick(1'b0, nov);
      if (s_en) begin
        en_cnt++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (s_done) begin
        if (nd < 3) done_at[nd] = i;
        nd++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_done_count", 32'(nd), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("b2b_done_cycle", 32'(done_at[k]), 32'(5 + k * (Ovl ? 4 : 5)));
    chk("b2b_wr_cycles", 32'(en_cnt), 32'd12);
    chk("b2b_max_run", 32'(maxrun), Ovl ? 32'd12 : 32'd4);

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      rand_inputs();
      if (i == 700) do_reset();
      tick(1'b0, nov);
    end
    in_valid = 1'b0; mem_ready = 1'b1;
    repeat (8) tick(1'b0, nov);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
